// File: rtl/tag_compare_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tag_compare_pipe
// Brief    : Two-stage pipelined tag compare against a small valid-tagged store,
//            valid/ready on both sides. Optional per-entry don't-care masks via
//            the TAG_COMPARE_MASK_EN macro.
// Revision : 1.0 - initial pipelined, parametrised release
// ============================================================================
module tag_compare_pipe #(
    parameter int TAG_W   = 4,
    parameter int ENTRIES = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
`ifdef TAG_COMPARE_MASK_EN
    input  logic [TAG_W-1:0] wr_mask,
`endif
    input  logic             inv_all,
    input  logic             lk_valid,
    output logic             lk_ready,
    input  logic [TAG_W-1:0] busA,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_hit,
    output logic [IDX_W-1:0] res_idx,
    output logic             res_multi
);

    logic [TAG_W-1:0]   r_tag   [ENTRIES];
    logic               r_valid [ENTRIES];
`ifdef TAG_COMPARE_MASK_EN
    logic [TAG_W-1:0]   r_mask  [ENTRIES];
`endif

    logic               r_s1_v;
    logic [ENTRIES-1:0] r_s1_match;

    logic [ENTRIES-1:0] w_match;
    logic [ENTRIES-1:0] w_wr_sel;
    logic               w_out_adv;
    logic               w_s1_load;
    logic               w_hit;
    logic               w_multi;
    logic [IDX_W-1:0]   w_idx;

    assign w_out_adv = ~res_valid | res_ready;
    assign w_s1_load = ~r_s1_v | w_out_adv;
    assign lk_ready  = rst_n & w_s1_load;

    // Per-entry decode: an out-of-range wr_idx selects no entry, so the write drops.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        assign w_wr_sel[i] = wr_en && (wr_idx == IDX_W'(i));

`ifdef TAG_COMPARE_MASK_EN
        assign w_match[i] = r_valid[i] && (((r_tag[i] ^ busA) & ~r_mask[i]) == '0);
`else
        assign w_match[i] = r_valid[i] && (r_tag[i] == busA);
`endif

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_tag[i]   <= '0;
                r_valid[i] <= 1'b0;
            end else if (inv_all) begin
                r_valid[i] <= 1'b0;
            end else if (w_wr_sel[i]) begin
                r_tag[i]   <= wr_tag;
                r_valid[i] <= 1'b1;
            end
        end

`ifdef TAG_COMPARE_MASK_EN
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_mask[i] <= '0;
            end else if (!inv_all && w_wr_sel[i]) begin
                r_mask[i] <= wr_mask;
            end
        end
`endif
    end

    // Stage 1: freeze the match vector so later store writes cannot alter the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_v     <= 1'b0;
            r_s1_match <= '0;
        end else if (w_s1_load) begin
            r_s1_v     <= lk_valid;
            r_s1_match <= w_match;
        end
    end

    always_comb begin
        w_hit   = |r_s1_match;
        w_multi = |(r_s1_match & (r_s1_match - 1'b1));
        w_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_s1_match[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    // Stage 2: registered result, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_hit   <= 1'b0;
            res_idx   <= '0;
            res_multi <= 1'b0;
        end else if (w_out_adv) begin
            res_valid <= r_s1_v;
            if (r_s1_v) begin
                res_hit   <= w_hit;
                res_idx   <= w_idx;
                res_multi <= w_multi;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/tag_compare_pipe.md
Name: tag_compare_pipe

Overview:
- Parametrised, pipelined successor to the fixed 4-bit combinational tag compare.
- Holds a small store of ENTRIES tags, each with a valid bit.
- Accepts lookup tags on a valid/ready handshake and returns hit, matching index and multi-hit on a second valid/ready handshake.
- Sits between the bus-side address decode (lookup tag taken from busA upper bits) and the power-gating control that consumes the compare result.

Parameters:
- TAG_W, 4, tag width in bits (1..32)
- ENTRIES, 8, number of tag-store entries (2..32)
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden

Ports:
- clk  in  1  single clock, all logic posedge
- rst_n  in  1  synchronous active-low reset
- wr_en  in  1  write one tag-store entry this cycle
- wr_idx  in  IDX_W  entry to write
- wr_tag  in  TAG_W  tag value written; entry valid set to 1
- inv_all  in  1  clear every entry valid bit
- lk_valid  in  1  lookup request valid
- lk_ready  out  1  lookup request accepted when lk_valid & lk_ready
- busA  in  TAG_W  lookup tag
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result when res_valid & res_ready
- res_hit  out  1  at least one valid entry matched
- res_idx  out  IDX_W  lowest matching index; 0 when no hit
- res_multi  out  1  two or more valid entries matched

Behaviour:
- Reset (rst_n=0 at posedge):
  - All entry valid bits = 0; stored tags = 0.
  - Stage-1 and stage-2 valids = 0.
  - res_valid=0, res_hit=0, res_idx=0, res_multi=0.
  - lk_ready=0 only during the reset cycle, 1 the cycle after.
- Reset mid-operation drops every in-flight lookup; no result is produced for it.
- Tag store:
  - wr_en writes tag[wr_idx]=wr_tag and sets valid[wr_idx]=1.
  - wr_idx >= ENTRIES: the write is ignored.
  - inv_all clears all valid bits; tags are left unchanged.
  - inv_all and wr_en in the same cycle: inv_all wins, and the written entry also ends invalid.
- Pipeline, two register stages:
  - S1 captures busA and the per-entry match vector: match[i] = valid[i] & (tag[i] == busA), computed from store contents before any same-cycle write.
  - S2 computes and registers res_hit (OR of match), res_idx (lowest set bit) and res_multi (popcount >= 2). S2 drives the outputs.
- Handshake:
  - out_adv = ~res_valid | res_ready.
  - S2 loads from S1 when out_adv. S1 loads when ~s1_v | out_adv.
  - lk_ready = ~s1_v | out_adv, combinational from registered state and res_ready.
  - Latency: a lookup accepted at edge t gives res_valid=1 after edge t+2 when res_ready stays high.
  - Throughput: 1 lookup per cycle.
  - res_valid=1 & res_ready=0: all outputs hold stable, and a lookup already in S1 keeps its captured match vector.
  - lk_valid high with lk_ready low: the request is not taken and busA must be held by the source.
- A write to an entry between a lookup's S1 capture and its result does not change that result.
- Empty store, or all entries invalid: res_hit=0, res_idx=0, res_multi=0.

Optional Feature:
- Macro TAG_COMPARE_MASK_EN.
- When defined:
  - Adds input port wr_mask (TAG_W).
  - Each entry stores a mask; a mask bit of 1 makes that tag bit don't-care.
  - Match rule: valid[i] & (((tag[i] ^ busA) & ~mask[i]) == 0).
  - Reset sets masks to 0. inv_all leaves masks unchanged.
- When undefined: no wr_mask port; exact compare only.

Test Plan:
- Reset with rst_n=0 for 2 cycles, release, then lookup busA=4'hA -> 2 cycles later res_valid=1, res_hit=0, res_idx=0, res_multi=0.
- Write idx3=4'h5, then look up 4'h5 with res_ready=1 -> res_hit=1, res_idx=3, res_multi=0 at acceptance+2.
- Write idx1=4'h7 and idx6=4'h7, then look up 4'h7 -> res_hit=1, res_idx=1, res_multi=1.
- Back-to-back lookups 4'h5, 4'h7, 4'h0 with res_ready low for 3 cycles -> lk_ready deasserts once S1 and S2 are full; results then appear in order with no drops or duplicates.
- wr_en idx2=4'hC together with inv_all, then look up 4'hC -> res_hit=0.
- Lookup accepted in the same cycle as a write of its tag -> miss.
- With TAG_COMPARE_MASK_EN: write idx0 tag=4'h8 mask=4'h7, look up 4'hB -> res_hit=1, res_idx=0.
